fft_frame_feeder: RTL and testbench

Parametrised successor to the FIR→FIFO→FFT glue. It buffers a continuous sample stream and emits exact N-point frames with Avalon-ST valid/sop/eop to the FFT sink, honouring sink_ready backpressure. It supports continuous and armed single-shot capture, counts dropped samples and sent frames, and indexes and checks the FFT output stream. It sits between the FIR filter output and the FFT IP.

---
 rtl/fft_feed_pkg.sv | 20 ++
 rtl/sync_fifo_fwft.sv | 54 +++++
 rtl/fft_frame_feeder.sv | 156 +++++++++++++++
 tb/tb_fft_frame_feeder.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_feed_pkg.sv
// Shared types and helpers for the FFT frame feeder: FSM states, default frame geometry,
// and a saturating counter increment.
package fft_feed_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    SEND = 2'd2
  } state_t;

  localparam int LOG2N_DEF = 9;
  localparam int N         = 1 << LOG2N_DEF;
  localparam int DEPTH     = 2 * N;

  // Holds at max_v instead of wrapping; callers zero-extend counters up to 32 bits.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO, depth 2**AW; a write at cycle t shows at dout at t+1.
// A write while full is accepted only when paired with a read in the same cycle.
module sync_fifo_fwft #(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic          rd_en,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);

  localparam int DEPTH_I = 1 << AW;

  logic [DW-1:0] mem [DEPTH_I];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  // Storage is deliberately left unreset; only the pointers define contents.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (level == DEPTH_I[AW:0]);
  assign empty = (level == '0);

endmodule

// File: rtl/fft_frame_feeder.sv
// Buffers a free-running sample stream and emits exact N-point Avalon-ST frames to the FFT,
// holding outputs under fft_ready backpressure; also indexes and checks the FFT output framing.
module fft_frame_feeder
  import fft_feed_pkg::*;
#(
  parameter int DW    = 32,
  parameter int LOG2N = LOG2N_DEF,
  parameter int AW    = LOG2N + 1,
  parameter int CW    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic             arm,
  input  logic             in_valid,
  input  logic [DW-1:0]    in_data,
  input  logic             fft_ready,
  output logic             fft_valid,
  output logic [DW-1:0]    fft_data,
  output logic             fft_sop,
  output logic             fft_eop,
  input  logic             src_valid,
  input  logic             src_sop,
  input  logic             src_eop,
  output logic [LOG2N-1:0] bin_idx,
  output logic             bin_valid,
  output logic             bin_err,
  output logic             busy,
  output logic [CW-1:0]    ovf_cnt,
  output logic [CW-1:0]    frame_cnt
);

  localparam int          FRAME_N   = 1 << LOG2N;
  localparam int          LAST_I    = FRAME_N - 1;
  localparam logic [AW:0] LVL_N     = FRAME_N[AW:0];
  localparam logic [LOG2N-1:0] LAST_BEAT = LAST_I[LOG2N-1:0];
  localparam logic [31:0] CNT_MAX   = 32'({CW{1'b1}});

  state_t           state;
  state_t           state_nxt;
  logic             load_mode;
  logic             mode_q;
  logic [LOG2N-1:0] beat;

  logic [DW-1:0]    fifo_dout;
  logic [AW:0]      level;
  logic             fifo_full;
  logic             fifo_empty;

  logic             pop;
  logic             wr_window;
  logic             wr_en;
  logic             drop;
  logic             last_hs;

  assign pop       = (state == SEND) && fft_ready && !fifo_empty;
  assign wr_window = (state != IDLE);
  assign wr_en     = wr_window && in_valid && (!fifo_full || pop);
  assign drop      = wr_window && in_valid && fifo_full && !pop;
  assign last_hs   = pop && (beat == LAST_BEAT);

  sync_fifo_fwft #(
    .DW(DW),
    .AW(AW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (wr_en),
    .rd_en (pop),
    .din   (in_data),
    .dout  (fifo_dout),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // mode is re-latched on every entry to FILL, so a change during SEND lands at the frame boundary.
  always_comb begin
    state_nxt = state;
    load_mode = 1'b0;
    case (state)
      IDLE: begin
        if (!mode || arm) begin
          state_nxt = FILL;
          load_mode = 1'b1;
        end
      end
      FILL: begin
        if (level >= LVL_N) state_nxt = SEND;
      end
      SEND: begin
        if (last_hs) begin
          if (mode_q) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = FILL;
            load_mode = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mode_q    <= 1'b0;
      beat      <= '0;
      frame_cnt <= '0;
      ovf_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (load_mode) mode_q <= mode;
      if (pop) beat <= last_hs ? '0 : beat + 1'b1;
      if (last_hs) frame_cnt <= frame_cnt + 1'b1;
      if (drop) ovf_cnt <= CW'(sat_inc(32'(ovf_cnt), CNT_MAX));
    end
  end

  assign fft_valid = (state == SEND);
  assign fft_data  = fft_valid ? fifo_dout : '0;
  assign fft_sop   = fft_valid && (beat == '0);
  assign fft_eop   = fft_valid && (beat == LAST_BEAT);
  assign busy      = (state != IDLE);

  logic [LOG2N-1:0] idx_next;
  logic [LOG2N-1:0] idx_now;
  logic             in_frame;
  logic             err_now;

  // idx_next wraps at N by width, so a sop right after a full frame expects index 0.
  assign idx_next = bin_idx + 1'b1;
  assign idx_now  = src_sop ? '0 : idx_next;
  assign err_now  = src_valid &&
                    ((src_eop && (idx_now != LAST_BEAT)) ||
                     (src_sop && in_frame && (idx_next != '0)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_idx   <= '0;
      bin_valid <= 1'b0;
      bin_err   <= 1'b0;
      in_frame  <= 1'b0;
    end else begin
      bin_valid <= src_valid;
      bin_err   <= err_now;
      if (src_valid) begin
        bin_idx <= idx_now;
        if (src_eop)      in_frame <= 1'b0;
        else if (src_sop) in_frame <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Bench for fft_frame_feeder at N=8: queue-based reference model checked every cycle,
// directed scenarios pinned with literal expectations, then a randomized soak.
module tb_fft_frame_feeder;

  localparam int DW    = 32;
  localparam int LOG2N = 3;
  localparam int N     = 8;
  localparam int CW    = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             mode = 1'b0;
  logic             arm = 1'b0;
  logic             in_valid = 1'b0;
  logic [DW-1:0]    in_data = '0;
  logic             fft_ready = 1'b0;
  logic             fft_valid;
  logic [DW-1:0]    fft_data;
  logic             fft_sop;
  logic             fft_eop;
  logic             src_valid = 1'b0;
  logic             src_sop = 1'b0;
  logic             src_eop = 1'b0;
  logic [LOG2N-1:0] bin_idx;
  logic             bin_valid;
  logic             bin_err;
  logic             busy;
  logic [CW-1:0]    ovf_cnt;
  logic [CW-1:0]    frame_cnt;

  fft_frame_feeder #(.DW(DW), .LOG2N(LOG2N), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .arm(arm),
    .in_valid(in_valid), .in_data(in_data),
    .fft_ready(fft_ready), .fft_valid(fft_valid), .fft_data(fft_data),
    .fft_sop(fft_sop), .fft_eop(fft_eop),
    .src_valid(src_valid), .src_sop(src_sop), .src_eop(src_eop),
    .bin_idx(bin_idx), .bin_valid(bin_valid), .bin_err(bin_err),
    .busy(busy), .ovf_cnt(ovf_cnt), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: FIFO as a queue, plus frame position and counters.
  logic [DW-1:0] mq[$];
  int  m_st;        // 0 waiting, 1 collecting, 2 streaming a frame
  int  m_beat;
  int  m_frames;
  int  m_ovf;
  bit  m_mode_q;
  int  m_bidx;
  bit  m_inframe;
  bit  m_bvalid;
  bit  m_berr;
  int  sent_data[$];
  bit  sent_sop[$];
  bit  sent_eop[$];

  int  dut_hs, dut_sop_hs, dut_eop_hs, dut_err_pulses, dut_valid_cycles;
  bit  prev_stall;
  logic [DW-1:0] prev_data;
  logic prev_sop, prev_eop;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_st = 0; m_beat = 0; m_frames = 0; m_ovf = 0; m_mode_q = 0;
    m_bidx = 0; m_inframe = 0; m_bvalid = 0; m_berr = 0;
    prev_stall = 0;
  endtask

  task automatic model_step();
    int old_size = mq.size();
    bit pop = (m_st == 2) && fft_ready;
    bit full = (old_size == 2 * N);
    if (pop) begin
      sent_data.push_back(int'(mq[0]));
      sent_sop.push_back(m_beat == 0);
      sent_eop.push_back(m_beat == N - 1);
      void'(mq.pop_front());
    end
    if (m_st != 0 && in_valid) begin
      if (!full || pop) mq.push_back(in_data);
      else if (m_ovf < 65535) m_ovf++;
    end
    case (m_st)
      0: if (!mode || arm) begin m_st = 1; m_mode_q = mode; end
      1: if (old_size >= N) m_st = 2;
      2: if (pop) begin
           if (m_beat == N - 1) begin
             m_beat = 0;
             m_frames = (m_frames + 1) % 65536;
             if (m_mode_q) m_st = 0;
             else begin m_st = 1; m_mode_q = mode; end
           end else begin
             m_beat++;
           end
         end
      default: m_st = 0;
    endcase
    m_bvalid = src_valid;
    m_berr = 0;
    if (src_valid) begin
      int idx;
      idx = src_sop ? 0 : (m_bidx + 1) % N;
      m_berr = (src_eop && idx != N - 1) || (src_sop && m_inframe && ((m_bidx + 1) % N) != 0);
      m_bidx = idx;
      if (src_sop) m_inframe = 1;
      if (src_eop) m_inframe = 0;
    end
  endtask

  // Compare process: outputs are sampled mid-cycle, then the model advances past the next edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      model_reset();
      chk("rst fft_valid", fft_valid, 0);
      chk("rst fft_data", fft_data, 0);
      chk("rst fft_sop", fft_sop, 0);
      chk("rst fft_eop", fft_eop, 0);
      chk("rst busy", busy, 0);
      chk("rst ovf_cnt", ovf_cnt, 0);
      chk("rst frame_cnt", frame_cnt, 0);
      chk("rst bin_idx", bin_idx, 0);
      chk("rst bin_valid", bin_valid, 0);
      chk("rst bin_err", bin_err, 0);
      chk("rst level", dut.u_fifo.level, 0);
    end else begin
      chk("fft_valid", fft_valid, m_st == 2);
      chk("fft_data", fft_data, (m_st == 2) ? mq[0] : 0);
      chk("fft_sop", fft_sop, (m_st == 2) && (m_beat == 0));
      chk("fft_eop", fft_eop, (m_st == 2) && (m_beat == N - 1));
      chk("busy", busy, m_st != 0);
      chk("ovf_cnt", ovf_cnt, m_ovf);
      chk("frame_cnt", frame_cnt, m_frames);
      chk("bin_valid", bin_valid, m_bvalid);
      chk("bin_idx", bin_idx, m_bidx);
      chk("bin_err", bin_err, m_berr);
      if (prev_stall) begin
        chk("hold valid", fft_valid, 1);
        chk("hold data", fft_data, prev_data);
        chk("hold sop", fft_sop, prev_sop);
        chk("hold eop", fft_eop, prev_eop);
      end
      prev_stall = fft_valid && !fft_ready;
      prev_data = fft_data;
      prev_sop = fft_sop;
      prev_eop = fft_eop;
      if (fft_valid) dut_valid_cycles++;
      if (fft_valid && fft_ready) begin
        dut_hs++;
        if (fft_sop) dut_sop_hs++;
        if (fft_eop) dut_eop_hs++;
      end
      if (bin_err) dut_err_pulses++;
      model_step();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    sent_data.delete(); sent_sop.delete(); sent_eop.delete();
    dut_hs = 0; dut_sop_hs = 0; dut_eop_hs = 0; dut_err_pulses = 0; dut_valid_cycles = 0;
  endtask

  task automatic do_reset(input bit m);
    rst_n = 0; mode = m; arm = 0; in_valid = 0; in_data = '0; fft_ready = 0;
    src_valid = 0; src_sop = 0; src_eop = 0;
    repeat (3) tick();
    rst_n = 1;
    clear_logs();
    tick();
  endtask

  task automatic ramp(input int first, input int count);
    for (int v = 0; v < count; v++) begin
      in_valid = 1; in_data = DW'(first + v);
      tick();
    end
    in_valid = 0;
  endtask

  initial begin
    bit found;

    // Continuous capture of a 1..24 ramp: three back-to-back frames.
    do_reset(0);
    fft_ready = 1;
    tick();
    ramp(1, 24);
    repeat (40) tick();
    chk("t1 frame_cnt", frame_cnt, 3);
    chk("t1 ovf_cnt", ovf_cnt, 0);
    chk("t1 model frames", m_frames, 3);
    chk("t1 beats", sent_data.size(), 24);
    chk("t1 first data", sent_data[0], 1);
    chk("t1 first sop", sent_sop[0], 1);
    chk("t1 beat8 data", sent_data[7], 8);
    chk("t1 beat8 eop", sent_eop[7], 1);
    chk("t1 last data", sent_data[23], 24);
    chk("t1 level", dut.u_fifo.level, 0);

    // Ready toggling every cycle: one frame, 8 beats, one sop and one eop.
    do_reset(0);
    fork
      begin
        for (int i = 0; i < 50; i++) begin
          fft_ready = ~fft_ready;
          tick();
        end
      end
      begin
        tick();
        ramp(1, 8);
      end
    join
    fft_ready = 0;
    chk("t2 handshakes", dut_hs, 8);
    chk("t2 sop count", dut_sop_hs, 1);
    chk("t2 eop count", dut_eop_hs, 1);
    chk("t2 frame_cnt", frame_cnt, 1);

    // Overflow with ready held low: 20 samples into 16 slots.
    do_reset(0);
    tick();
    ramp(1, 20);
    tick();
    chk("t3 ovf_cnt", ovf_cnt, 4);
    chk("t3 model ovf", m_ovf, 4);
    chk("t3 level full", dut.u_fifo.level, 16);
    fft_ready = 1;
    repeat (40) tick();
    chk("t3 frame_cnt", frame_cnt, 2);
    chk("t3 beats", sent_data.size(), 16);
    chk("t3 f1 first", sent_data[0], 1);
    chk("t3 f2 first", sent_data[8], 9);
    chk("t3 f2 sop", sent_sop[8], 1);
    chk("t3 f2 last", sent_data[15], 16);

    // Single-shot: ignored until armed, then exactly one frame.
    do_reset(1);
    fft_ready = 1;
    ramp(1, 10);
    tick();
    chk("t4 idle busy", busy, 0);
    chk("t4 idle valid cycles", dut_valid_cycles, 0);
    arm = 1;
    tick();
    arm = 0;
    ramp(50, 8);
    repeat (30) tick();
    chk("t4 frame_cnt", frame_cnt, 1);
    chk("t4 busy after", busy, 0);
    chk("t4 beats", sent_data.size(), 8);
    chk("t4 first", sent_data[0], 50);
    chk("t4 last", sent_data[7], 57);

    // FFT output indexing: clean frame, then one with an early eop.
    do_reset(0);
    for (int b = 0; b < N; b++) begin
      src_valid = 1; src_sop = (b == 0); src_eop = (b == N - 1);
      tick();
      chk("t5 bin_idx", bin_idx, b);
    end
    src_valid = 0; src_sop = 0; src_eop = 0;
    tick();
    chk("t5 clean err pulses", dut_err_pulses, 0);
    for (int b = 0; b < N; b++) begin
      src_valid = 1; src_sop = (b == 0); src_eop = (b == 5);
      tick();
    end
    src_valid = 0; src_sop = 0; src_eop = 0;
    repeat (2) tick();
    chk("t5 early eop err pulses", dut_err_pulses, 1);

    // Reset at beat 4 of a frame, then a clean frame after resuming.
    do_reset(0);
    fft_ready = 1;
    tick();
    ramp(1, 8);
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (m_st == 2 && m_beat == 4) found = 1;
      else tick();
    end
    chk("t6 reached beat 4", found, 1);
    rst_n = 0;
    #1;
    chk("t6 valid in reset", fft_valid, 0);
    chk("t6 level in reset", dut.u_fifo.level, 0);
    tick();
    rst_n = 1;
    clear_logs();
    tick();
    ramp(100, 8);
    repeat (30) tick();
    chk("t6 frame_cnt", frame_cnt, 1);
    chk("t6 beats", sent_data.size(), 8);
    chk("t6 first", sent_data[0], 100);
    chk("t6 first sop", sent_sop[0], 1);
    chk("t6 sop count", dut_sop_hs, 1);

    // Randomized soak in continuous mode with random backpressure and FFT framing.
    do_reset(0);
    for (int i = 0; i < 2500; i++) begin
      in_valid  = ($urandom_range(9) < 7);
      in_data   = $urandom;
      fft_ready = ($urandom_range(9) < 6);
      src_valid = $urandom_range(1);
      src_sop   = ($urandom_range(7) == 0);
      src_eop   = ($urandom_range(7) == 0);
      tick();
    end
    in_valid = 0; src_valid = 0; src_sop = 0; src_eop = 0;
    fft_ready = 1;
    repeat (60) tick();
    chk("rand frame_cnt", frame_cnt, m_frames);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
